// File: rtl/p_register_pkg.sv
// Shared types and sizing helpers for the modular-multiplier P accumulator.
package p_register_pkg;

    typedef enum logic [1:0] {
        P_HOLD = 2'd0,
        P_MULT = 2'd1,
        P_SUB  = 2'd2
    } p_op_t;

    // Two guard bits keep 2*acc + Y < 3M representable while acc < M.
    function automatic int acc_width(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/p_cond_sub.sv
// Combinational compare-and-subtract: diff = acc - m, borrow set when acc < m.
module p_cond_sub #(
    parameter int W = 10
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] m,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign borrow = (acc < m);
    assign diff   = acc - m;

endmodule

// File: rtl/p_register.sv
// P accumulator of the interleaved modular multiplier: P = acc[n-1:0].
// Define P_REGISTER_FULLSUB_EN to make one sub pulse reduce acc below M (2M then M).
module p_register
    import p_register_pkg::*;
#(
    parameter int n = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [n-1:0]         X,
    input  logic [n-1:0]         Y,
    input  logic [n-1:0]         M,
    input  logic [$clog2(n)-1:0] iter,
    input  logic                 mult,
    input  logic                 sub,
    output logic [n-1:0]         P
);

    localparam int W = acc_width(n);

    logic [W-1:0] acc;
    logic [W-1:0] acc_next;
    logic [W-1:0] addend;
    logic [W-1:0] sub_value;
    logic [W-1:0] m_ext;
    logic [W-1:0] diff_m;
    logic         borrow_m;
    logic [n-1:0] x_shifted;
    logic         x_bit;
    p_op_t        op;

    assign m_ext = {2'b00, M};

    // Out-of-range iter selects a zero bit rather than wrapping.
    assign x_shifted = X >> iter;
    assign x_bit     = x_shifted[0] && (int'(iter) < n);
    assign addend    = x_bit ? {2'b00, Y} : '0;

    p_cond_sub #(.W(W)) u_sub_m (
        .acc    (acc),
        .m      (m_ext),
        .diff   (diff_m),
        .borrow (borrow_m)
    );

`ifdef P_REGISTER_FULLSUB_EN
    logic [W-1:0] m2_ext;
    logic [W-1:0] diff_2m;
    logic         borrow_2m;

    assign m2_ext = {1'b0, M, 1'b0};

    p_cond_sub #(.W(W)) u_sub_2m (
        .acc    (acc),
        .m      (m2_ext),
        .diff   (diff_2m),
        .borrow (borrow_2m)
    );

    always_comb begin
        sub_value = acc;
        if (!borrow_2m) begin
            sub_value = diff_2m;
        end else if (!borrow_m) begin
            sub_value = diff_m;
        end
    end
`else
    assign sub_value = borrow_m ? acc : diff_m;
`endif

    always_comb begin
        op = P_HOLD;
        if (mult) begin
            op = P_MULT;
        end else if (sub) begin
            op = P_SUB;
        end
    end

    always_comb begin
        acc_next = acc;
        case (op)
            P_MULT:  acc_next = {acc[W-2:0], 1'b0} + addend;
            P_SUB:   acc_next = sub_value;
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    assign P = acc[n-1:0];

endmodule

// File: tb/tb_p_register.sv
// Self-checking bench for p_register: directed scenarios plus randomized full multiplies.
module tb_p_register;

    localparam int n       = 8;
    localparam int IW      = $clog2(n);
    localparam int ACCMASK = (1 << (n + 2)) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [n-1:0]  X, Y, M, P;
    logic [IW-1:0] iter;
    logic          mult, sub;

    int checks    = 0;
    int failures  = 0;
    int model_acc = 0;

    p_register #(.n(n)) dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .Y     (Y),
        .M     (M),
        .iter  (iter),
        .mult  (mult),
        .sub   (sub),
        .P     (P)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int expected);
        logic [n-1:0] exp_p;
        exp_p = expected[n-1:0];
        checks++;
        assert (P === exp_p) else begin
            failures++;
            $error("[TB] FAIL %s: P=%0d expected %0d", tag, P, exp_p);
        end
    endtask

    // Reference model works on plain integers: shift-and-add, then reduce by M.
    task automatic applyStimulus(input logic m, input logic s, input int x, input int y,
                                 input int mm, input int it, input string tag);
        @(negedge clk);
        mult = m;
        sub  = s;
        X    = x[n-1:0];
        Y    = y[n-1:0];
        M    = mm[n-1:0];
        iter = it[IW-1:0];
        if (m) begin
            model_acc = (model_acc * 2 + ((((x >> it) & 1) != 0) ? y : 0)) & ACCMASK;
        end else if (s) begin
`ifdef P_REGISTER_FULLSUB_EN
            if (model_acc >= 2 * mm) model_acc = model_acc - 2 * mm;
            else if (model_acc >= mm) model_acc = model_acc - mm;
`else
            if (model_acc >= mm) model_acc = model_acc - mm;
`endif
        end
        @(posedge clk);
        #1;
        mult = 1'b0;
        sub  = 1'b0;
        checkOutput(tag, model_acc);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 checkOutput("reset_async", 0);
        model_acc = 0;
        mult = 1'b1;
        X = '1;
        Y = 8'd1;
        @(posedge clk);
        #1 checkOutput("reset_hold", 0);
        mult = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 checkOutput("reset_release", 0);
    endtask

    initial begin
        int x, y, m;
        reset = 1'b0;
        mult  = 1'b0;
        sub   = 1'b0;
        X     = '0;
        Y     = '0;
        M     = 8'd1;
        iter  = '0;
        #1 checkOutput("reset_state", 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset from P=0xA5
        applyStimulus(1'b1, 1'b0, 1, 8'hA5, 8'hFF, 0, "load_a5");
        checkOutput("load_a5_const", 8'hA5);
        resetPulse();

        // Single step with X[4]=0
        applyStimulus(1'b1, 1'b0, 7, 2, 10, 4, "single_mult");
        checkOutput("single_mult_const", 0);
        applyStimulus(1'b0, 1'b1, 7, 2, 10, 4, "single_sub");

        // Full multiply 7*2 mod 10
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b0, 7, 2, 10, i, "mul7x2_mult");
            applyStimulus(1'b0, 1'b1, 7, 2, 10, i, "mul7x2_sub1");
            applyStimulus(1'b0, 1'b1, 7, 2, 10, i, "mul7x2_sub2");
        end
        checkOutput("mul7x2_final", 4);

        // Priority: mult wins over sub
        resetPulse();
        applyStimulus(1'b1, 1'b0, 1, 3, 10, 0, "prio_load3");
        applyStimulus(1'b1, 1'b1, 1, 2, 10, 0, "prio_both");
        checkOutput("prio_const", 8);

        // Subtract boundaries
        resetPulse();
        applyStimulus(1'b1, 1'b0, 1, 5, 10, 0, "bnd_load5");
        applyStimulus(1'b1, 1'b0, 0, 5, 10, 0, "bnd_load10");
        applyStimulus(1'b0, 1'b1, 0, 5, 10, 0, "bnd_sub_eq");
        checkOutput("bnd_eq_const", 0);
        applyStimulus(1'b1, 1'b0, 1, 9, 10, 0, "bnd_load9");
        applyStimulus(1'b0, 1'b1, 1, 9, 10, 0, "bnd_sub_lt");
        checkOutput("bnd_lt_const", 9);

        // acc=25, M=10: one and two sub pulses
        resetPulse();
        applyStimulus(1'b1, 1'b0, 1, 8, 10, 0, "fs_load8");
        applyStimulus(1'b1, 1'b0, 1, 9, 10, 0, "fs_load25");
        applyStimulus(1'b0, 1'b1, 0, 0, 10, 0, "fs_sub1");
`ifdef P_REGISTER_FULLSUB_EN
        checkOutput("fs_sub1_const", 5);
`else
        checkOutput("fs_sub1_const", 15);
`endif
        applyStimulus(1'b0, 1'b1, 0, 0, 10, 0, "fs_sub2");
        checkOutput("fs_sub2_const", 5);

        // Randomized full multiplies against X*Y mod M
        for (int t = 0; t < 20; t++) begin
            resetPulse();
            m = int'($urandom_range(1, 255));
            y = int'($urandom_range(0, m - 1));
            x = int'($urandom_range(0, 255));
            for (int i = n - 1; i >= 0; i--) begin
                applyStimulus(1'b1, ($urandom_range(0, 1) == 1), x, y, m, i, "rnd_mult");
                applyStimulus(1'b0, 1'b1, x, y, m, i, "rnd_sub1");
                applyStimulus(1'b0, 1'b1, x, y, m, i, "rnd_sub2");
                applyStimulus(1'b0, 1'b0, x, y, m, i, "rnd_hold");
            end
            checkOutput("rnd_modmul", (x * y) % m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
